// File: rtl/count_run_ctrl.sv
// count_run_ctrl: run/pause/clear sequencer for a 4-digit BCD counter.
// Conditions the start and clear buttons, generates the count-enable tick
// from a prescaled system clock, and stops counting on a BCD target match.
module count_run_ctrl #(
   parameter int unsigned CLK_HZ    = 100000000,
   parameter int unsigned TICK_HZ   = 10,
   parameter int unsigned DB_CYCLES = 1000000
) (
   input  logic        clk_100MHz,
   input  logic        reset_n,
   input  logic        btn_start,
   input  logic        btn_clear,
   input  logic        target_en,
   input  logic [15:0] target_bcd,
   input  logic [3:0]  ones,
   input  logic [3:0]  tens,
   input  logic [3:0]  hundreds,
   input  logic [3:0]  thousands,
   output logic        cnt_tick,
   output logic        cnt_clr,
   output logic [1:0]  state,
   output logic        running,
   output logic        done
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int unsigned DBW = $clog2(DB_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;

   // Button path, index 0 = start, index 1 = clear
   logic [1:0]      btn_raw;
   logic [1:0]      sync1, sync2;
   logic [1:0]      db_lvl, db_prev;
   logic [DBW-1:0]  db_cnt [2];
   logic            ev_start, ev_clear;

   logic            target_ok;
   logic            match;

   assign btn_raw = {btn_clear, btn_start};

   // Two-flop synchroniser for both raw buttons
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // Debounce: accept a new level after DB_CYCLES consecutive differing samples
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         db_lvl  <= '0;
         db_prev <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         db_prev <= db_lvl;
         for (int unsigned i = 0; i < 2; i++) begin
            if (sync2[i] == db_lvl[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
               db_lvl[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Press events on the debounced rising edge only
   assign ev_start = db_lvl[0] & ~db_prev[0];
   assign ev_clear = db_lvl[1] & ~db_prev[1];

   // Target compare; a non-BCD target nibble can never match
   always_comb begin
      target_ok = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         if (target_bcd[i*4 +: 4] > 4'd9) begin
            target_ok = 1'b0;
         end
      end
   end

   assign match = target_en && target_ok &&
                  ({thousands, hundreds, tens, ones} == target_bcd);

   // State, prescaler and status flags
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         presc_q <= '0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         running <= (state_d == RUN);
         done    <= (state_d == DONE);
      end
   end

   // Next state, prescaler and pulses: clear > start > target match > tick
   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      cnt_tick = 1'b0;
      cnt_clr  = 1'b0;
      if (ev_clear) begin
         state_d = IDLE;
         cnt_clr = 1'b1;
         presc_d = '0;
      end else if (ev_start) begin
         unique case (state_q)
            IDLE: begin
               state_d = RUN;
               presc_d = '0;
            end
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end else if (state_q == RUN) begin
         if (match) begin
            state_d = DONE;
         end else if (presc_q == PW'(DIV - 1)) begin
            cnt_tick = 1'b1;
            presc_d  = '0;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_count_run_ctrl.sv
// Testbench for count_run_ctrl with a BCD counter model closing the loop.
module tb_count_run_ctrl;

   logic        clk;
   logic        rst_n;
   logic        btn_start;
   logic        btn_clear;
   logic        target_en;
   logic [15:0] target_bcd;
   logic        cnt_tick;
   logic        cnt_clr;
   logic [1:0]  state;
   logic        running;
   logic        done;

   logic [15:0] m_dig;
   logic [15:0] tbl_dig;
   logic        use_tbl;
   logic [15:0] dig;
   logic        tick_s;
   logic        clr_s;
   int          n_tick;
   int          n_clr;
   int          n_cmp;
   int          n_bad;

   typedef struct {
      logic        en;
      logic [15:0] tgt;
      logic [15:0] dg;
      logic [1:0]  exp_st;
   } vec_t;

   vec_t tbl [7];

   assign dig = use_tbl ? tbl_dig : m_dig;

   count_run_ctrl #(
      .CLK_HZ   (100),
      .TICK_HZ  (10),
      .DB_CYCLES(4)
   ) dut (
      .clk_100MHz(clk),
      .reset_n   (rst_n),
      .btn_start (btn_start),
      .btn_clear (btn_clear),
      .target_en (target_en),
      .target_bcd(target_bcd),
      .ones      (dig[3:0]),
      .tens      (dig[7:4]),
      .hundreds  (dig[11:8]),
      .thousands (dig[15:12]),
      .cnt_tick  (cnt_tick),
      .cnt_clr   (cnt_clr),
      .state     (state),
      .running   (running),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Pulses sampled mid-cycle so the counter model sees settled values
   always @(negedge clk) begin
      tick_s <= cnt_tick;
      clr_s  <= cnt_clr;
      if (cnt_tick) n_tick <= n_tick + 1;
      if (cnt_clr)  n_clr  <= n_clr + 1;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)      m_dig <= 16'h0000;
      else if (clr_s)  m_dig <= 16'h0000;
      else if (tick_s) m_dig <= bcd_inc(m_dig);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int t;
      int c;
      int w;
      n_cmp = 0; n_bad = 0; n_tick = 0; n_clr = 0;
      tick_s = 1'b0; clr_s = 1'b0;
      rst_n = 1'b0; btn_start = 1'b0; btn_clear = 1'b0;
      target_en = 1'b0; target_bcd = 16'h0000;
      use_tbl = 1'b0; tbl_dig = 16'h0000;

      tbl[0] = '{1'b1, 16'h0012, 16'h0012, 2'b11};
      tbl[1] = '{1'b1, 16'h0012, 16'h0013, 2'b01};
      tbl[2] = '{1'b0, 16'h0012, 16'h0012, 2'b01};
      tbl[3] = '{1'b1, 16'h9999, 16'h9999, 2'b11};
      tbl[4] = '{1'b1, 16'h00A0, 16'h00A0, 2'b01};
      tbl[5] = '{1'b1, 16'h0000, 16'h0000, 2'b11};
      tbl[6] = '{1'b1, 16'h1234, 16'h1243, 2'b01};

      // Reset values
      step(2);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_tick", 32'(cnt_tick), 32'd0);
      chk("rst_clr", 32'(cnt_clr), 32'd0);
      chk("rst_flags", 32'({running, done}), 32'd0);
      rst_n = 1'b1;

      // 1: start, latency, tick cadence
      btn_start = 1'b1;
      step(6);  chk("s1_pre_state", 32'(state), 32'd0);
      step(1);  chk("s1_run_state", 32'(state), 32'd1);
      chk("s1_running", 32'(running), 32'd1);
      t = n_tick;
      step(8);  chk("s1_tick_early", 32'(cnt_tick), 32'd0);
      step(1);  chk("s1_first_tick", 32'(cnt_tick), 32'd1);
      step(1);  chk("s1_dig1", 32'(m_dig), 32'h0001);
      step(3);  btn_start = 1'b0;
      step(37);
      chk("s1_dig5", 32'(m_dig), 32'h0005);
      chk("s1_ticks5", 32'(n_tick - t), 32'd5);
      chk("s1_still_run", 32'(state), 32'd1);

      // 2: pause and resume keep the tick phase
      btn_start = 1'b1;
      step(6);  chk("s2_pre_pause", 32'(state), 32'd1);
      step(1);  chk("s2_pause", 32'(state), 32'd2);
      chk("s2_running0", 32'(running), 32'd0);
      t = n_tick;
      step(13); btn_start = 1'b0;
      step(15); btn_start = 1'b1;
      step(6);
      chk("s2_paused_state", 32'(state), 32'd2);
      chk("s2_no_ticks", 32'(n_tick - t), 32'd0);
      chk("s2_dig_held", 32'(m_dig), 32'h0005);
      step(1);  chk("s2_resume", 32'(state), 32'd1);
      step(2);  chk("s2_tick_before", 32'(cnt_tick), 32'd0);
      step(1);  chk("s2_phase_tick", 32'(cnt_tick), 32'd1);
      step(1);  chk("s2_dig6", 32'(m_dig), 32'h0006);
      step(9);  btn_start = 1'b0;

      // 4a: clear mid-RUN at 0047
      w = 0;
      while (m_dig != 16'h0047 && w < 600) begin
         step(1);
         w++;
      end
      chk("s4_reach47", 32'(m_dig), 32'h0047);
      btn_clear = 1'b1;
      c = n_clr;
      step(6);
      chk("s4_clr_pulse", 32'(cnt_clr), 32'd1);
      chk("s4_clr_state_run", 32'(state), 32'd1);
      step(1);
      chk("s4_idle", 32'(state), 32'd0);
      chk("s4_dig0", 32'(m_dig), 32'h0000);
      chk("s4_clr_low", 32'(cnt_clr), 32'd0);
      step(13); btn_clear = 1'b0;
      chk("s4_one_clr", 32'(n_clr - c), 32'd1);
      step(10);

      // 3: target 0012 stops after exactly 12 ticks
      target_en = 1'b1; target_bcd = 16'h0012;
      btn_start = 1'b1;
      step(7);  chk("s3_run", 32'(state), 32'd1);
      t = n_tick;
      step(9);  chk("s3_first_tick", 32'(cnt_tick), 32'd1);
      step(4);  btn_start = 1'b0;
      step(107);
      chk("s3_last_run", 32'(state), 32'd1);
      chk("s3_dig12", 32'(m_dig), 32'h0012);
      chk("s3_match_notick", 32'(cnt_tick), 32'd0);
      step(1);
      chk("s3_done_state", 32'(state), 32'd3);
      chk("s3_flags", 32'({running, done}), 32'b01);
      chk("s3_ticks12", 32'(n_tick - t), 32'd12);
      step(20);
      chk("s3_frozen", 32'(m_dig), 32'h0012);
      chk("s3_no_more", 32'(n_tick - t), 32'd12);
      btn_start = 1'b1; step(20); btn_start = 1'b0; step(10);
      chk("s3_start_ignored", 32'(state), 32'd3);

      // 4b: clear from DONE
      btn_clear = 1'b1;
      step(6);
      chk("s4b_clr_pulse", 32'(cnt_clr), 32'd1);
      chk("s4b_done_state", 32'(state), 32'd3);
      step(1);
      chk("s4b_idle", 32'(state), 32'd0);
      chk("s4b_dig0", 32'(m_dig), 32'h0000);
      chk("s4b_done0", 32'(done), 32'd0);
      step(13); btn_clear = 1'b0; step(10);

      // 5: simultaneous press, clear wins
      target_en = 1'b0;
      c = n_clr;
      btn_start = 1'b1; btn_clear = 1'b1;
      step(6);
      chk("s5_clr_pulse", 32'(cnt_clr), 32'd1);
      step(1);  chk("s5_idle", 32'(state), 32'd0);
      step(20);
      chk("s5_still_idle", 32'(state), 32'd0);
      chk("s5_one_clr", 32'(n_clr - c), 32'd1);
      btn_start = 1'b0; btn_clear = 1'b0; step(10);

      // 6a: 2-cycle glitch is rejected
      btn_start = 1'b1; step(2); btn_start = 1'b0;
      step(20);
      chk("s6_glitch_idle", 32'(state), 32'd0);

      // 6b: asynchronous reset mid-RUN
      btn_start = 1'b1;
      step(7);  chk("s6_run", 32'(state), 32'd1);
      step(13); btn_start = 1'b0;
      step(25);
      #3 rst_n = 1'b0;
      #1;
      chk("s6_rst_state", 32'(state), 32'd0);
      chk("s6_rst_outs", 32'({cnt_tick, cnt_clr, running, done}), 32'd0);
      step(2);
      rst_n = 1'b1;
      t = n_tick;
      step(20);
      chk("s6_post_rst_idle", 32'(state), 32'd0);
      chk("s6_post_rst_noticks", 32'(n_tick - t), 32'd0);

      // Table: match decision on the first RUN cycle with forced digits
      use_tbl = 1'b1;
      for (int i = 0; i < 7; i++) begin
         rst_n = 1'b0; step(1); rst_n = 1'b1;
         target_en  = tbl[i].en;
         target_bcd = tbl[i].tgt;
         tbl_dig    = tbl[i].dg;
         btn_start  = 1'b1;
         step(7);
         chk($sformatf("tbl%0d_run", i), 32'(state), 32'd1);
         chk($sformatf("tbl%0d_notick", i), 32'(cnt_tick), 32'd0);
         step(1);
         chk($sformatf("tbl%0d_next", i), 32'(state), 32'(tbl[i].exp_st));
         step(12); btn_start = 1'b0;
         step(10);
         chk($sformatf("tbl%0d_hold", i), 32'(state), 32'(tbl[i].exp_st));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
